crtc_timing_gen: RTL and testbench

- Single-clock, register-programmable CRTC timing and address generator. Successor to the current sync/dot timing chain.
- Produces hsync, vsync, display enable, the video RAM character address (MA) and the character scanline address (RA) from a character-clock enable.
- Adds register writes, vertical fine adjust, programmable display start, and a frame pulse.
- Sits between the CPU register bus and the dot/pixel shifter.

---
 rtl/crtc_timing_gen.sv | 278 +++++++++++++++++++++++++++
 tb/tb_crtc_timing_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_timing_gen.sv
// ---------------------------------------------------------------------------
// crtc_timing_gen
//
// Register-programmable CRTC timing and address generator. From a character
// clock enable it produces horizontal/vertical sync, display enable, the
// video RAM character address (MA), the scanline within the character row
// (RA) and a one-clock frame pulse. Supports vertical fine adjust lines and
// a programmable display start address.
//
// Registers (index: meaning, reset value):
//   R0  horizontal total - 1 (last hc of a scanline)          63
//   R1  horizontal displayed characters                         40
//   R2  hsync start position                                    48
//   R3  [3:0] hsync width, [7:4] vsync width (0 means 16)     0x15
//   R4  vertical total rows - 1 (7 bits used)                   32
//   R5  vertical adjust scanlines                                0
//   R6  vertical displayed rows (7 bits used)                   25
//   R7  vsync row position                                      28
//   R9  max scanline address within a row                        7
//   R12 display start high (6 bits used)                      0x10
//   R13 display start low                                     0x00
//
// Ports:
//   clk_i       system clock
//   reset_n_i   asynchronous active-low reset
//   char_en_i   character clock enable; counters advance only when high
//   reg_we_i    register write strobe
//   reg_addr_i  register index (writes to unlisted indices are dropped)
//   reg_data_i  register write data
//   h_sync_o    horizontal sync
//   v_sync_o    vertical sync
//   de_o        display enable
//   ma_o        character address
//   ra_o        scanline within the character row
//   frame_o     one-clock pulse after the character that restarts a frame
// ---------------------------------------------------------------------------
module crtc_timing_gen #(
  parameter int MA_WIDTH    = 14,
  parameter int RA_WIDTH    = 5,
  parameter int SYNC_W_BITS = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                char_en_i,
  input  logic                reg_we_i,
  input  logic [4:0]          reg_addr_i,
  input  logic [7:0]          reg_data_i,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                de_o,
  output logic [MA_WIDTH-1:0] ma_o,
  output logic [RA_WIDTH-1:0] ra_o,
  output logic                frame_o
);

  // Vertical state machine encoding
  localparam logic [0:0] ST_ROWS = 1'b0;
  localparam logic [0:0] ST_ADJ  = 1'b1;

  localparam logic [MA_WIDTH-1:0] MA_ONE = MA_WIDTH'(1);
  localparam logic [RA_WIDTH-1:0] RA_ONE = RA_WIDTH'(1);

  // Sync width field decode: a zero field selects the maximum width.
  function automatic logic [8:0] sync_width(input logic [SYNC_W_BITS-1:0] f);
    logic [8:0] w;
    w = '0;
    if (f == '0) begin
      w[SYNC_W_BITS] = 1'b1;
    end else begin
      w[SYNC_W_BITS-1:0] = f;
    end
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [7:0]          r0_q, r1_q, r2_q, r3_q, r5_q, r7_q, r13_q;
  logic [6:0]          r4_q, r6_q;
  logic [RA_WIDTH-1:0] r9_q;
  logic [5:0]          r12_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r0_q  <= 8'd63;
      r1_q  <= 8'd40;
      r2_q  <= 8'd48;
      r3_q  <= 8'h15;
      r4_q  <= 7'd32;
      r5_q  <= 8'd0;
      r6_q  <= 7'd25;
      r7_q  <= 8'd28;
      r9_q  <= RA_WIDTH'(7);
      r12_q <= 6'h10;
      r13_q <= 8'h00;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        5'd0:    r0_q  <= reg_data_i;
        5'd1:    r1_q  <= reg_data_i;
        5'd2:    r2_q  <= reg_data_i;
        5'd3:    r3_q  <= reg_data_i;
        5'd4:    r4_q  <= reg_data_i[6:0];
        5'd5:    r5_q  <= reg_data_i;
        5'd6:    r6_q  <= reg_data_i[6:0];
        5'd7:    r7_q  <= reg_data_i;
        5'd9:    r9_q  <= reg_data_i[RA_WIDTH-1:0];
        5'd12:   r12_q <= reg_data_i[5:0];
        5'd13:   r13_q <= reg_data_i;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Counter state
  // -------------------------------------------------------------------------
  logic [7:0]          hc_q, hc_d;
  logic [RA_WIDTH-1:0] ra_q, ra_d;
  logic [6:0]          vc_q, vc_d;
  logic [7:0]          adj_q, adj_d;
  logic [0:0]          vst_q, vst_d;
  logic [8:0]          vsc_q, vsc_d;
  logic                vs_q, vs_d;
  logic [MA_WIDTH-1:0] ma_q, ma_d;
  logic [MA_WIDTH-1:0] rs_q, rs_d;
  logic                hs_q, hs_d;
  logic                de_q, de_d;
  logic                frame_q;

  logic [MA_WIDTH-1:0] start_addr;
  logic [MA_WIDTH-1:0] rs_next_row;
  logic [8:0]          hsw;
  logic [8:0]          vsw;
  logic [7:0]          h_off;
  logic                h_act;
  logic                line_end;
  logic                row_last;
  logic                frame_last_row;
  logic                adj_last;
  logic                restart;

  assign start_addr     = MA_WIDTH'({r12_q, r13_q});
  assign rs_next_row    = rs_q + MA_WIDTH'(r1_q);
  assign hsw            = sync_width(r3_q[SYNC_W_BITS-1:0]);
  assign vsw            = sync_width(r3_q[4 +: SYNC_W_BITS]);
  assign h_act          = (hc_q < r1_q);
  // >= rather than == so a total shrunk below the current count wraps at once
  assign line_end       = (hc_q >= r0_q);
  assign row_last       = (ra_q >= r9_q);
  assign frame_last_row = (vc_q >= r4_q);
  assign adj_last       = (({1'b0, adj_q} + 9'd1) >= {1'b0, r5_q});

  // Next counter state for one character advance
  always_comb begin
    hc_d    = hc_q;
    ra_d    = ra_q;
    vc_d    = vc_q;
    adj_d   = adj_q;
    vst_d   = vst_q;
    ma_d    = ma_q;
    rs_d    = rs_q;
    restart = 1'b0;

    if (line_end) begin
      hc_d = 8'd0;
      ma_d = rs_q;
      if (vst_q == ST_ROWS) begin
        if (row_last) begin
          // Row finished: next row begins R1 characters further on
          ra_d = '0;
          rs_d = rs_next_row;
          ma_d = rs_next_row;
          if (frame_last_row) begin
            if (r5_q != 8'd0) begin
              vst_d = ST_ADJ;
              adj_d = 8'd0;
            end else begin
              restart = 1'b1;
            end
          end else begin
            vc_d = vc_q + 7'd1;
          end
        end else begin
          ra_d = ra_q + RA_ONE;
        end
      end else begin
        // Adjust lines keep counting RA upward from zero
        if (adj_last) begin
          restart = 1'b1;
        end else begin
          adj_d = adj_q + 8'd1;
          ra_d  = ra_q + RA_ONE;
        end
      end

      if (restart) begin
        hc_d  = 8'd0;
        ra_d  = '0;
        vc_d  = 7'd0;
        adj_d = 8'd0;
        vst_d = ST_ROWS;
        ma_d  = start_addr;
        rs_d  = start_addr;
      end
    end else begin
      hc_d = hc_q + 8'd1;
      if (h_act) begin
        ma_d = ma_q + MA_ONE;
      end
    end
  end

  // Registered outputs are derived from the next counter state so they
  // reflect the counters with no added latency.
  always_comb begin
    h_off = hc_d - r2_q;
    hs_d  = ({1'b0, h_off} < hsw);
    de_d  = (hc_d < r1_q) && (vst_d == ST_ROWS) && (vc_d < r6_q);

    vs_d  = vs_q;
    vsc_d = vsc_q;
    if (line_end) begin
      if (vs_q) begin
        // While active, start conditions are ignored
        if ((vsc_q + 9'd1) >= vsw) begin
          vs_d  = 1'b0;
          vsc_d = 9'd0;
        end else begin
          vsc_d = vsc_q + 9'd1;
        end
      end else if ((vst_d == ST_ROWS) && ({1'b0, vc_d} == r7_q) && (ra_d == '0)) begin
        vs_d  = 1'b1;
        vsc_d = 9'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hc_q    <= 8'd0;
      ra_q    <= '0;
      vc_q    <= 7'd0;
      adj_q   <= 8'd0;
      vst_q   <= ST_ROWS;
      vsc_q   <= 9'd0;
      vs_q    <= 1'b0;
      ma_q    <= MA_WIDTH'(14'h1000);
      rs_q    <= MA_WIDTH'(14'h1000);
      hs_q    <= 1'b0;
      de_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      // Pulse lasts one clk regardless of the next enable
      frame_q <= char_en_i & restart;
      if (char_en_i) begin
        hc_q  <= hc_d;
        ra_q  <= ra_d;
        vc_q  <= vc_d;
        adj_q <= adj_d;
        vst_q <= vst_d;
        vsc_q <= vsc_d;
        vs_q  <= vs_d;
        ma_q  <= ma_d;
        rs_q  <= rs_d;
        hs_q  <= hs_d;
        de_q  <= de_d;
      end
    end
  end

  assign h_sync_o = hs_q;
  assign v_sync_o = vs_q;
  assign de_o     = de_q;
  assign ma_o     = ma_q;
  assign ra_o     = ra_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_crtc_timing_gen.sv
// ---------------------------------------------------------------------------
// Testbench for crtc_timing_gen: a table of expected outputs at chosen
// character counts under reset defaults, hand-written corner sequences, and
// a randomized run compared against a line/row level reference model.
// ---------------------------------------------------------------------------
module tb_crtc_timing_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        char_en = 1'b0;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [7:0]  reg_data = '0;
  logic        h_sync, v_sync, de, frame;
  logic [13:0] ma;
  logic [4:0]  ra;

  int checks = 0;
  int failures = 0;
  bit use_model = 0;

  always #5 clk = ~clk;

  crtc_timing_gen #(.MA_WIDTH(14), .RA_WIDTH(5), .SYNC_W_BITS(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .char_en_i(char_en),
    .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .h_sync_o(h_sync), .v_sync_o(v_sync), .de_o(de),
    .ma_o(ma), .ra_o(ra), .frame_o(frame)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (line/row level) ----------------
  int mr[32];
  int m_hc, m_line, m_row, m_adjl, m_ma, m_rs, m_vsc;
  bit m_in_adj, m_vs;
  logic e_hs, e_vs, e_de, e_fr;
  logic [4:0] e_ra;
  logic [13:0] e_ma;

  function automatic int m_start();
    return (((mr[12] & 63) << 8) | mr[13]) % 16384;
  endfunction

  task automatic model_reset();
    foreach (mr[i]) mr[i] = 0;
    mr[0] = 63; mr[1] = 40; mr[2] = 48; mr[3] = 'h15; mr[4] = 32; mr[5] = 0;
    mr[6] = 25; mr[7] = 28; mr[9] = 7; mr[12] = 'h10; mr[13] = 0;
    m_hc = 0; m_line = 0; m_row = 0; m_adjl = 0; m_in_adj = 0;
    m_vs = 0; m_vsc = 0;
    m_rs = 'h1000; m_ma = 'h1000;
    e_hs = 0; e_vs = 0; e_de = 1; e_fr = 0; e_ra = 0; e_ma = 14'h1000;
  endtask

  // Called at the end of every scanline; returns 1 if the frame restarts.
  task automatic model_new_line(output bit fr);
    int vsw;
    fr = 0;
    vsw = ((mr[3] >> 4) & 15) == 0 ? 16 : ((mr[3] >> 4) & 15);
    m_ma = m_rs;
    if (m_in_adj) begin
      if (m_adjl + 1 >= mr[5]) fr = 1;
      else m_adjl++;
    end else if (m_line < (mr[9] & 31)) begin
      m_line++;
    end else begin
      m_line = 0;
      m_rs = (m_rs + mr[1]) % 16384;
      m_ma = m_rs;
      if (m_row < (mr[4] & 127)) m_row++;
      else if (mr[5] != 0) begin m_in_adj = 1; m_adjl = 0; end
      else fr = 1;
    end
    if (fr) begin
      m_line = 0; m_row = 0; m_adjl = 0; m_in_adj = 0;
      m_rs = m_start(); m_ma = m_rs;
    end
    if (m_vs) begin
      m_vsc++;
      if (m_vsc >= vsw) m_vs = 0;
    end else if (!m_in_adj && m_row == mr[7] && m_line == 0) begin
      m_vs = 1; m_vsc = 0;
    end
  endtask

  task automatic model_step(input logic ce, input logic we, input logic [4:0] a, input logic [7:0] d);
    bit fr;
    int hsw;
    fr = 0;
    if (ce) begin
      if (m_hc < mr[0]) begin
        if (m_hc < mr[1]) m_ma = (m_ma + 1) % 16384;
        m_hc++;
      end else begin
        m_hc = 0;
        model_new_line(fr);
      end
      hsw  = (mr[3] & 15) == 0 ? 16 : (mr[3] & 15);
      e_hs = (((m_hc - mr[2]) & 255) < hsw);
      e_de = (m_hc < mr[1]) && !m_in_adj && (m_row < (mr[6] & 127));
      e_vs = m_vs;
      e_ra = 5'(m_in_adj ? m_adjl : m_line);
      e_ma = 14'(m_ma);
    end
    e_fr = fr;
    if (we && (a <= 7 || a == 9 || a == 12 || a == 13)) mr[a] = d;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic ce, input logic we, input logic [4:0] a, input logic [7:0] d);
    char_en = ce; reg_we = we; reg_addr = a; reg_data = d;
    model_step(ce, we, a, d);
    @(posedge clk); #1;
    char_en = 0; reg_we = 0;
    if (use_model)
      chk("model_outputs", {h_sync, v_sync, de, frame, ra, ma},
          {e_hs, e_vs, e_de, e_fr, e_ra, e_ma});
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  task automatic ce_n(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset_n = 0; char_en = 0; reg_we = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_reset();
  endtask

  typedef struct {
    int n;
    logic de, hs, vs, fr;
    logic [4:0] ra;
    logic [13:0] ma;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int n, logic de_e, logic hs_e, logic vs_e, logic fr_e,
                              logic [4:0] ra_e, logic [13:0] ma_e);
    vec_t v;
    v.n = n; v.de = de_e; v.hs = hs_e; v.vs = vs_e; v.fr = fr_e; v.ra = ra_e; v.ma = ma_e;
    tbl.push_back(v);
  endfunction

  initial begin
    int idx, cnt, fpulses, first_fr;

    //      n      de hs vs fr ra  ma
    add(0,     1, 0, 0, 0, 0, 14'h1000);
    add(39,    1, 0, 0, 0, 0, 14'h1027);
    add(40,    0, 0, 0, 0, 0, 14'h1028);
    add(47,    0, 0, 0, 0, 0, 14'h1028);
    add(48,    0, 1, 0, 0, 0, 14'h1028);
    add(52,    0, 1, 0, 0, 0, 14'h1028);
    add(53,    0, 0, 0, 0, 0, 14'h1028);
    add(64,    1, 0, 0, 0, 1, 14'h1000);
    add(511,   0, 0, 0, 0, 7, 14'h1028);
    add(512,   1, 0, 0, 0, 0, 14'h1028);
    add(12327, 1, 0, 0, 0, 0, 14'h13E7);
    add(12328, 0, 0, 0, 0, 0, 14'h13E8);
    add(12800, 0, 0, 0, 0, 0, 14'h13E8);
    add(14335, 0, 0, 0, 0, 7, 14'h1460);
    add(14336, 0, 0, 1, 0, 0, 14'h1460);
    add(14400, 0, 0, 0, 0, 1, 14'h1460);
    add(16895, 0, 0, 0, 0, 7, 14'h1528);
    add(16896, 1, 0, 0, 1, 0, 14'h1000);
    add(16897, 1, 0, 0, 0, 0, 14'h1001);

    // Table walk under reset defaults, one char_en per clk
    do_reset();
    idx = 0; fpulses = 0;
    for (int n = 0; n <= 16897; n++) begin
      if (n > 0) begin
        step(1'b1, 1'b0, 5'd0, 8'd0);
        if (frame) fpulses++;
      end
      while (idx < tbl.size() && tbl[idx].n == n) begin
        chk($sformatf("tbl_n%0d_de", n), de, tbl[idx].de);
        chk($sformatf("tbl_n%0d_hs", n), h_sync, tbl[idx].hs);
        chk($sformatf("tbl_n%0d_vs", n), v_sync, tbl[idx].vs);
        chk($sformatf("tbl_n%0d_fr", n), frame, tbl[idx].fr);
        chk($sformatf("tbl_n%0d_ra", n), ra, tbl[idx].ra);
        chk($sformatf("tbl_n%0d_ma", n), ma, tbl[idx].ma);
        idx++;
      end
    end
    chk("default_frame_pulses", fpulses, 1);

    // Vsync width 16 on 8-char lines: scanlines 224..239
    do_reset();
    wr(5'd0, 8'd7); wr(5'd1, 8'd4); wr(5'd3, 8'h05);
    ce_n(224 * 8 - 1);
    chk("vsw16_before", v_sync, 1'b0);
    ce_n(1);
    chk("vsw16_rise", v_sync, 1'b1);
    ce_n(16 * 8 - 1);
    chk("vsw16_last", v_sync, 1'b1);
    ce_n(1);
    chk("vsw16_fall", v_sync, 1'b0);
    chk("vsw16_fall_ra", ra, 5'd0);

    // Vertical adjust of 3 lines and new display start
    do_reset();
    wr(5'd0, 8'd7); wr(5'd1, 8'd4); wr(5'd5, 8'd3); wr(5'd6, 8'd40);
    wr(5'd12, 8'h00); wr(5'd13, 8'h10);
    fpulses = 0; first_fr = -1;
    for (int n = 1; n <= 2136; n++) begin
      step(1'b1, 1'b0, 5'd0, 8'd0);
      if (frame) begin
        fpulses++;
        if (first_fr < 0) first_fr = n;
      end
      if (n == 2104) chk("adj_last_row_de", de, 1'b1);
      if (n == 2112) begin chk("adj0_de", de, 1'b0); chk("adj0_ra", ra, 5'd0); end
      if (n == 2120) begin chk("adj1_de", de, 1'b0); chk("adj1_ra", ra, 5'd1); end
      if (n == 2128) begin chk("adj2_de", de, 1'b0); chk("adj2_ra", ra, 5'd2); end
      if (n == 2136) begin chk("adj_restart_ma", ma, 14'h0010); chk("adj_restart_de", de, 1'b1); end
    end
    chk("adj_frame_pulses", fpulses, 1);
    chk("adj_frame_at", first_fr, 2136);
    step(1'b0, 1'b0, 5'd0, 8'd0);
    chk("frame_drop_no_ce", frame, 1'b0);

    // Shrinking R0 below hc wraps on the next char_en
    do_reset();
    ce_n(50);
    chk("shrink_pre_ma", ma, 14'h1028);
    wr(5'd0, 8'd10);
    ce_n(1);
    chk("shrink_ra", ra, 5'd1);
    chk("shrink_ma", ma, 14'h1000);

    // Write coinciding with char_en uses the old R0
    do_reset();
    ce_n(50);
    step(1'b1, 1'b1, 5'd0, 8'd10);
    chk("coincide_ra", ra, 5'd0);
    chk("coincide_ma", ma, 14'h1028);
    ce_n(1);
    chk("coincide_next_ra", ra, 5'd1);
    chk("coincide_next_ma", ma, 14'h1000);

    // Hsync width field 0 -> 16 chars; indices 16/17 must not alias R0/R1
    do_reset();
    wr(5'd16, 8'd5); wr(5'd17, 8'd0); wr(5'd3, 8'h10);
    ce_n(64);
    chk("alias_de", de, 1'b1);
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      ce_n(1);
      if (h_sync) cnt++;
    end
    chk("hsw16_count", cnt, 16);

    // Hsync wrapping through hc=255 -> 0
    do_reset();
    wr(5'd0, 8'd255); wr(5'd2, 8'd250); wr(5'd3, 8'h1A);
    ce_n(249); chk("hwrap_249", h_sync, 1'b0);
    ce_n(1);   chk("hwrap_250", h_sync, 1'b1);
    ce_n(5);   chk("hwrap_255", h_sync, 1'b1);
    ce_n(1);   chk("hwrap_0", h_sync, 1'b1);
    ce_n(3);   chk("hwrap_3", h_sync, 1'b1);
    ce_n(1);   chk("hwrap_4", h_sync, 1'b0);

    // Asynchronous reset mid-line with char_en held off
    do_reset();
    ce_n(20);
    chk("midline_ma", ma, 14'h1014);
    #2 reset_n = 0;
    #1;
    chk("areset_ma", ma, 14'h1000);
    chk("areset_misc", {h_sync, v_sync, de, frame, ra}, {1'b0, 1'b0, 1'b1, 1'b0, 5'd0});
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    ce_n(1);
    chk("after_release_ma", ma, 14'h1001);
    chk("after_release_de", de, 1'b1);

    // Randomized run against the reference model
    do_reset();
    use_model = 1;
    wr(5'd0, 8'd12); wr(5'd4, 8'd3); wr(5'd9, 8'd2); wr(5'd7, 8'd2);
    for (int i = 0; i < 6000; i++) begin
      logic ce, we;
      logic [4:0] a;
      logic [7:0] d;
      int k;
      ce = ($urandom % 4) != 0;
      we = ($urandom % 12) == 0;
      k  = $urandom % 14;
      d  = 8'($urandom);
      case (k)
        0:  begin a = 5'd0;  d = 8'(3 + $urandom % 18); end
        1:  begin a = 5'd1;  d = 8'($urandom % 24); end
        2:  begin a = 5'd2;  d = 8'($urandom % 24); end
        3:  a = 5'd3;
        4:  begin a = 5'd4;  d = 8'($urandom % 6); end
        5:  begin a = 5'd5;  d = 8'($urandom % 4); end
        6:  begin a = 5'd6;  d = 8'($urandom % 8); end
        7:  begin a = 5'd7;  d = 8'($urandom % 8); end
        8:  begin a = 5'd9;  d = 8'($urandom % 4); end
        9:  a = 5'd12;
        10: a = 5'd13;
        11: a = 5'd8;
        12: a = 5'd20;
        default: a = 5'd31;
      endcase
      step(ce, we, a, d);
    end
    use_model = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
